// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage; owns the PC and the instruction SRAM request,
// and latches a branch redirect that arrives while fetch is stalled.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC,
  parameter int          STALL_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic [32:0]        br_bus,
  output logic [32:0]        if_to_id_bus,
  output logic               inst_sram_en,
  output logic [3:0]         inst_sram_wen,
  output logic [31:0]        inst_sram_addr,
  output logic [31:0]        inst_sram_wdata
);
  logic        r_ce;
  logic        r_br_pend;
  logic [31:0] r_pc;
  logic [31:0] r_br_pend_addr;
  logic        w_br_e;
  logic [31:0] w_br_addr;
  logic [31:0] w_next_pc;
  logic        w_unused;
  assign w_br_e    = br_bus[32];
  assign w_br_addr = br_bus[31:0];
  assign w_unused  = ^stall[STALL_W-1:1];
  // A live redirect beats a pending one, which beats sequential fetch.
  assign w_next_pc = w_br_e ? w_br_addr : r_br_pend ? r_br_pend_addr : r_pc + 32'd4;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc           <= RESET_PC;
      r_ce           <= 1'b0;
      r_br_pend      <= 1'b0;
      r_br_pend_addr <= 32'b0;
    end else if (!stall[0]) begin
      r_pc      <= w_next_pc;
      r_ce      <= 1'b1;
      r_br_pend <= 1'b0;
    end else if (w_br_e) begin
      r_br_pend      <= 1'b1;
      r_br_pend_addr <= w_br_addr;
    end
  end
  assign if_to_id_bus    = {r_ce, r_pc};
  assign inst_sram_en    = r_ce;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_addr  = r_pc;
  assign inst_sram_wdata = 32'b0;
endmodule
